mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares the processor's single 8-bit program/data memory between the CPU controller and a host program loader/debug port. Each requester issues single-word read or write transactions over a req/gnt/done handshake. The block serializes them onto the one memory port with round-robin arbitration and a host lock that is used during program download. It sits between the controller's memory-side signals and the memory.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU transaction request (level)
- cpu_write  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted and fields latched
- cpu_done  out  1  one-cycle pulse: CPU transaction complete
- cpu_rdata  out  DATA_W  last CPU read data (registered)
- host_req, host_write, host_addr, host_wdata, host_gnt, host_done, host_rdata: same as the cpu_* ports, for the host port
- host_lock  in  1  while high, CPU requests are not granted
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data; valid one cycle after mem_addr is presented
- busy  out  1  high in every state except IDLE

## Operation
State machine: IDLE → SETUP → ACCESS → DONE → IDLE.

- **IDLE**
  - Arbitrate on request levels.
  - Eligible requesters: host if host_req; CPU if cpu_req and not host_lock.
  - One eligible requester: that requester wins.
  - Both eligible: the requester that is not `last_owner` wins.
  - On a win:
    - latch owner, write, addr and wdata;
    - pulse the winner's gnt;
    - update `last_owner`;
    - go to SETUP.
  - No eligible requester: stay in IDLE.
- **SETUP**: drive latched addr and wdata onto mem_addr/mem_wdata; mem_write = 0.
- **ACCESS**: hold mem_addr/mem_wdata.
  - Write: mem_write = 1 for exactly this cycle.
  - Read: capture mem_rdata into the owner's rdata register at the end of this cycle.
- **DONE**: pulse the owner's done; the owner's rdata is valid in this cycle. Next state is IDLE.

Requester rules:
- Hold req, write, addr and wdata stable from req assertion until gnt.
- Fields are don't-care after gnt.
- A req seen high in IDLE is a new request. A requester wanting one transaction deasserts req on the edge after done.
- req dropped after gnt: the transaction still completes and done still pulses.
- req dropped before gnt: nothing happens.

Other rules:
- The rdata registers update only on that port's read completion and otherwise hold.
- A write never alters either rdata register.
- host_lock changes take effect at the next IDLE arbitration. An in-flight CPU transaction completes normally.
- A CPU request held pending under lock is granted at the first IDLE after the lock drops, unless a host request wins round-robin in that cycle.
- mem_addr and mem_wdata hold their last values in IDLE and DONE; mem_write = 0 outside ACCESS.

## Timing
- Reset values:
  - state IDLE;
  - all gnt, done and mem_write = 0;
  - busy = 0;
  - mem_addr = 0, mem_wdata = 0;
  - cpu_rdata = 0, host_rdata = 0;
  - last_owner = host, so the CPU wins the first simultaneous request.
- Latency: gnt in the IDLE cycle where req is sampled (cycle 0); mem_write or read capture in cycle 2; done in cycle 3.
- Cadence: one transaction per 4 cycles; back-to-back arbitration occurs at every IDLE.
- Simultaneous requests alternate strictly, cpu/host/cpu/…, when lock is low.
- Reset mid-transaction:
  - next state is IDLE;
  - mem_write is forced to 0 at that edge;
  - the in-flight transaction is dropped and no done is issued;
  - rdata registers are cleared.
- gnt and done never assert on both ports in the same cycle.
- Address wrap is the caller's concern; 0xFF is a legal address.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding constants ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE (2-bit);
  - owner constants OWN_CPU = 0, OWN_HOST = 1.
  - Follows the same style as the existing states/instructions include files.
- One natural sub-module: `mem_arb_pick`, a combinational two-way round-robin picker.
  - Inputs: cpu_req, host_req, host_lock, last_owner.
  - Outputs: grant_valid, grant_owner.
- The FSM, latches and rdata registers stay in `mem_arbiter`.

## Test plan
- **Reset, then CPU read:** CPU reads 0x10 with memory holding 0xA5.
  - cpu_gnt at cycle 0, cpu_done at cycle 3, cpu_rdata = 0xA5.
  - host_rdata stays 0; mem_write never asserts.
- **Host write:** host writes 0x3C to 0x20.
  - mem_write is high for exactly one cycle with mem_addr = 0x20, mem_wdata = 0x3C.
  - host_done follows one cycle later.
  - A later CPU read of 0x20 returns 0x3C.
- **Simultaneous requests, held high, lock low:**
  - grants are cpu, host, cpu, host, at cycles 0, 4, 8, 12;
  - no gnt coincides with another.
- **Host lock with CPU pending:** host_lock = 1, cpu_req held, host issues 3 writes.
  - No cpu_gnt appears.
  - After lock drops, cpu_gnt arrives at the next IDLE.
- **Reset in ACCESS of a write:** assert reset during the ACCESS cycle of a write.
  - mem_write = 0 on the next cycle and no done pulse.
  - All outputs are at reset values; a following request is granted normally.
- **req dropped right after gnt:**
  - the transaction completes;
  - done pulses at cycle 3;
  - no second grant follows.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the two-port memory arbiter.
//   ST_*   : 2-bit FSM state encodings (IDLE -> SETUP -> ACCESS -> DONE)
//   OWN_*  : owner encoding used for the transaction latch and last_owner
// Kept as plain localparams so legacy include-style code can use the same names.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational two-way round-robin picker.
// Ports:
//   cpu_req     in  CPU request level
//   host_req    in  host request level
//   host_lock   in  masks the CPU request while high
//   last_owner  in  owner of the previous grant (OWN_CPU / OWN_HOST)
//   grant_valid out at least one eligible requester
//   grant_owner out winning requester (meaningful only with grant_valid)
// -----------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic host_req,
  input  logic host_lock,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  logic cpu_elig;

  assign cpu_elig = cpu_req & ~host_lock;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = cpu_elig | host_req;
    grant_owner = OWN_CPU;
    if (cpu_elig && host_req) begin
      // Contention: the side that did not win last time goes first.
      grant_owner = (last_owner == OWN_CPU) ? OWN_HOST : OWN_CPU;
    end else if (host_req) begin
      grant_owner = OWN_HOST;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port program/data memory between the CPU controller and the
// host loader/debug port. Each transaction is one word, 4 cycles:
//   IDLE (arbitrate, gnt) -> SETUP (address out) -> ACCESS (write strobe or
//   read capture) -> DONE (done pulse, rdata valid).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/write/addr/wdata        CPU request fields (held until gnt)
//   cpu_gnt, cpu_done, cpu_rdata    CPU handshake pulses and read data register
//   host_*                          same set for the host port
//   host_lock                       blocks CPU grants while high
//   mem_addr, mem_wdata, mem_write  memory command (addr/wdata registered)
//   mem_rdata                       memory read data, one cycle after mem_addr
//   busy                            high in every state except IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  logic [1:0]        state_q,      state_d;
  logic              owner_q,      owner_d;
  logic              write_q,      write_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic grant_valid;
  logic grant_owner;
  logic win;

  mem_arb_pick u_pick (
    .cpu_req     (cpu_req),
    .host_req    (host_req),
    .host_lock   (host_lock),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // A grant is only issued from IDLE and never in a cycle where reset is
  // sampled, since that edge would discard the latched fields anyway.
  assign win = (state_q == ST_IDLE) && grant_valid && !reset;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    write_d      = write_q;
    last_owner_d = last_owner_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = ST_SETUP;
          owner_d      = grant_owner;
          last_owner_d = grant_owner;
          // The address/data latch doubles as the memory command register, so
          // it is already on mem_addr/mem_wdata during SETUP and holds after.
          if (grant_owner == OWN_HOST) begin
            write_d     = host_write;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
          end else begin
            write_d     = cpu_write;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        // Memory returns data one cycle after SETUP presented the address.
        if (!write_q) begin
          if (owner_q == OWN_HOST) host_rdata_d = mem_rdata;
          else                     cpu_rdata_d  = mem_rdata;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data-path registers are reset too because their zero value is visible on the ports after reset.
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      write_q      <= 1'b0;
      last_owner_q <= OWN_HOST;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      last_owner_q <= last_owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign cpu_gnt    = win && (grant_owner == OWN_CPU);
  assign host_gnt   = win && (grant_owner == OWN_HOST);
  assign cpu_done   = (state_q == ST_DONE) && (owner_q == OWN_CPU);
  assign host_done  = (state_q == ST_DONE) && (owner_q == OWN_HOST);
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_write  = (state_q == ST_ACCESS) && write_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. A small synchronous memory model sits on the
// memory port; a reference copy of its contents provides expected read data.
// Expected transactions are queued when stimulus is driven and retired by a
// monitor at every done pulse.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef struct {
    logic       own;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       cpu_req, cpu_write;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_gnt, cpu_done;
  logic       host_req, host_write;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       host_gnt, host_done;
  logic       host_lock;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_write;
  logic       busy;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  exp_t       sb [$];

  int total = 0;
  int bad   = 0;
  int n_wr  = 0;
  int n_cpu_gnt = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_done   (cpu_done),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_write (host_write),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_done  (host_done),
    .host_rdata (host_rdata),
    .host_lock  (host_lock),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data registered one cycle after the address.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic own, input logic wr, input logic [7:0] addr,
                          input logic [7:0] data);
    exp_t e;
    e.own  = own;
    e.wr   = wr;
    e.addr = addr;
    if (wr) begin
      ref_mem[addr] = data;
      e.data = data;
    end else begin
      e.data = ref_mem[addr];
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic own, input logic wr, input logic [7:0] addr,
                       input logic [7:0] data);
    if (own == OWN_HOST) begin
      host_write = wr; host_addr = addr; host_wdata = data; host_req = 1'b1;
    end else begin
      cpu_write = wr; cpu_addr = addr; cpu_wdata = data; cpu_req = 1'b1;
    end
  endtask

  // Follows one transaction from its IDLE grant cycle (cycle 0) to the
  // following IDLE (cycle 4); the requester drops req right after gnt.
  task automatic follow(input logic own, input logic wr, input logic [7:0] addr,
                        input logic [7:0] data);
    #1;
    check("gnt_c0",       own ? host_gnt : cpu_gnt, 1);
    check("gnt_other_c0", own ? cpu_gnt : host_gnt, 0);
    check("busy_c0",      busy, 0);
    tick();
    if (own == OWN_HOST) host_req = 1'b0; else cpu_req = 1'b0;
    check("busy_c1",      busy, 1);
    check("mem_addr_c1",  mem_addr, addr);
    check("mem_we_c1",    mem_write, 0);
    tick();
    check("mem_we_c2",    mem_write, wr);
    check("mem_addr_c2",  mem_addr, addr);
    if (wr) check("mem_wdata_c2", mem_wdata, data);
    tick();
    check("done_c3",      own ? host_done : cpu_done, 1);
    check("done_other_c3", own ? cpu_done : host_done, 0);
    check("mem_we_c3",    mem_write, 0);
    tick();
    check("busy_c4",      busy, 0);
    check("no_regrant_c4", cpu_gnt | host_gnt, 0);
    check("no_done_c4",   cpu_done | host_done, 0);
  endtask

  task automatic run_single(input logic own, input logic wr, input logic [7:0] addr,
                            input logic [7:0] data);
    push_exp(own, wr, addr, data);
    drive(own, wr, addr, data);
    follow(own, wr, addr, data);
  endtask

  // Monitor: exclusivity every cycle and scoreboard retirement on done.
  always @(negedge clk) begin
    if (!reset) begin
      check("gnt_exclusive",  cpu_gnt & host_gnt, 0);
      check("done_exclusive", cpu_done & host_done, 0);
      if (mem_write) n_wr++;
      if (cpu_gnt)   n_cpu_gnt++;
      if (cpu_done || host_done) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_owner", host_done, e.own);
          check("sb_addr",  mem_addr, e.addr);
          if (e.wr) check("sb_wdata", mem_wdata, e.data);
          else      check("sb_rdata", e.own ? host_rdata : cpu_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;

    reset = 1'b1; host_lock = 1'b0;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_write = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_busy",       busy, 0);
    check("rst_mem_write",  mem_write, 0);
    check("rst_gnt",        {cpu_gnt, host_gnt}, 0);
    check("rst_done",       {cpu_done, host_done}, 0);
    check("rst_mem_addr",   mem_addr, 0);
    check("rst_mem_wdata",  mem_wdata, 0);
    check("rst_cpu_rdata",  cpu_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);
    reset = 1'b0;

    // CPU read of 0x10.
    run_single(OWN_CPU, 1'b0, 8'h10, 8'h00);
    check("t1_cpu_rdata",  cpu_rdata, 8'hA5);
    check("t1_host_rdata", host_rdata, 0);
    check("t1_no_writes",  n_wr, 0);

    // Host write 0x3C to 0x20, then CPU reads it back.
    run_single(OWN_HOST, 1'b1, 8'h20, 8'h3C);
    check("t2_cpu_rdata_kept",  cpu_rdata, 8'hA5);
    check("t2_host_rdata_kept", host_rdata, 0);
    run_single(OWN_CPU, 1'b0, 8'h20, 8'h00);
    check("t2_readback", cpu_rdata, 8'h3C);

    // Host read of the top address; leaves last_owner = host.
    run_single(OWN_HOST, 1'b0, 8'hFF, 8'h00);
    check("t3_host_rdata_ff", host_rdata, 8'hA5);

    // Simultaneous held requests: cpu, host, cpu, host at cycles 0/4/8/12.
    push_exp(OWN_CPU,  1'b0, 8'h30, 8'h00);
    push_exp(OWN_HOST, 1'b1, 8'h40, 8'h77);
    push_exp(OWN_CPU,  1'b0, 8'h30, 8'h00);
    push_exp(OWN_HOST, 1'b1, 8'h40, 8'h77);
    drive(OWN_CPU,  1'b0, 8'h30, 8'h00);
    drive(OWN_HOST, 1'b1, 8'h40, 8'h77);
    #1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("rr_cpu_gnt_%0d", k),  cpu_gnt,  (k % 8) == 0);
      check($sformatf("rr_host_gnt_%0d", k), host_gnt, (k % 8) == 4);
      if (k == 13) begin
        cpu_req  = 1'b0;
        host_req = 1'b0;
      end
      tick();
    end
    check("rr_idle_busy", busy, 0);
    check("rr_idle_gnt",  cpu_gnt | host_gnt, 0);

    // Host lock with a CPU read pending: three host writes, no CPU grant.
    host_lock = 1'b1;
    drive(OWN_CPU, 1'b0, 8'h20, 8'h00);
    snap = n_cpu_gnt;
    run_single(OWN_HOST, 1'b1, 8'h60, 8'h01);
    run_single(OWN_HOST, 1'b1, 8'h61, 8'h02);
    run_single(OWN_HOST, 1'b1, 8'h62, 8'h03);
    check("lock_no_cpu_gnt", n_cpu_gnt - snap, 0);
    host_lock = 1'b0;
    push_exp(OWN_CPU, 1'b0, 8'h20, 8'h00);
    follow(OWN_CPU, 1'b0, 8'h20, 8'h00);
    check("lock_cpu_rdata", cpu_rdata, 8'h3C);

    // Reset during the ACCESS cycle of a host write: dropped, no done.
    drive(OWN_HOST, 1'b1, 8'h70, 8'h99);
    #1;
    check("rst_mid_gnt", host_gnt, 1);
    tick();
    host_req = 1'b0;
    tick();
    check("rst_mid_access_we", mem_write, 1);
    reset = 1'b1;
    tick();
    check("rst_mid_we",         mem_write, 0);
    check("rst_mid_busy",       busy, 0);
    check("rst_mid_done",       {cpu_done, host_done}, 0);
    check("rst_mid_mem_addr",   mem_addr, 0);
    check("rst_mid_mem_wdata",  mem_wdata, 0);
    check("rst_mid_cpu_rdata",  cpu_rdata, 0);
    check("rst_mid_host_rdata", host_rdata, 0);
    reset = 1'b0;
    tick();
    check("rst_after_done", {cpu_done, host_done}, 0);
    check("rst_after_busy", busy, 0);

    // Normal operation resumes after reset.
    run_single(OWN_CPU, 1'b1, 8'h80, 8'h42);
    run_single(OWN_CPU, 1'b0, 8'h80, 8'h00);
    check("post_rst_readback", cpu_rdata, 8'h42);

    tick();
    check("sb_drained",   sb.size(), 0);
    check("write_pulses", n_wr, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
